// File: rtl/keypad_digit_loader.sv
// rtl/keypad_digit_loader.sv - debounced keypad receiver shifting BCD digits into an MM:SS entry register
module keypad_digit_loader #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       clear,
    input  logic [3:0] D,
    input  logic       validn,
    output logic       enablen,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [2:0] digit_count,
    output logic       digit_strobe,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS   = 2'd1,
        CAPTURE = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LP_N   = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] LP_ONE = CNT_W'(1);

    state_t           r_state;
    logic [3:0]       r_d_hold;
    logic [CNT_W-1:0] r_cnt;

    logic [CNT_W-1:0] w_cnt_next;
    logic             w_cnt_done;

    assign w_cnt_next = r_cnt + LP_ONE;
    assign w_cnt_done = (w_cnt_next >= LP_N);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_d_hold     <= 4'd0;
            r_cnt        <= '0;
            enablen      <= 1'b1;
            min_tens     <= 4'd0;
            min_ones     <= 4'd0;
            sec_tens     <= 4'd0;
            sec_ones     <= 4'd0;
            digit_count  <= 3'd0;
            digit_strobe <= 1'b0;
            err          <= 1'b0;
        end else begin
            enablen      <= ~load;
            digit_strobe <= 1'b0;
            err          <= 1'b0;
            if (clear) begin
                // Clear beats everything, including a pending capture.
                r_state     <= IDLE;
                r_cnt       <= '0;
                min_tens    <= 4'd0;
                min_ones    <= 4'd0;
                sec_tens    <= 4'd0;
                sec_ones    <= 4'd0;
                digit_count <= 3'd0;
            end else if (!load) begin
                r_state <= IDLE;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (!validn) begin
                            r_d_hold <= D;
                            r_cnt    <= LP_ONE;
                            r_state  <= (LP_N <= LP_ONE) ? CAPTURE : PRESS;
                        end
                    end
                    PRESS: begin
                        if (validn || (D != r_d_hold)) begin
                            r_state <= IDLE;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= w_cnt_next;
                            if (w_cnt_done) begin
                                r_state <= CAPTURE;
                            end
                        end
                    end
                    CAPTURE: begin
                        if (r_d_hold <= 4'd9) begin
                            min_tens     <= min_ones;
                            min_ones     <= sec_tens;
                            sec_tens     <= sec_ones;
                            sec_ones     <= r_d_hold;
                            digit_count  <= (digit_count >= 3'd4) ? 3'd4 : digit_count + 3'd1;
                            digit_strobe <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                        r_state <= RELEASE;
                        r_cnt   <= '0;
                    end
                    RELEASE: begin
                        // Only a clean, stable release re-arms the next press.
                        if (validn) begin
                            r_cnt <= w_cnt_next;
                            if (w_cnt_done) begin
                                r_state <= IDLE;
                                r_cnt   <= '0;
                            end
                        end else begin
                            r_cnt <= '0;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_digit_loader.sv
// tb/tb_keypad_digit_loader.sv - directed self-checking bench for keypad_digit_loader
module tb_keypad_digit_loader;

    logic       clk;
    logic       reset;
    logic       load;
    logic       clear;
    logic [3:0] D;
    logic       validn;
    logic       enablen;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic [2:0] digit_count;
    logic       digit_strobe;
    logic       err;

    int total;
    int bad;
    int cyc;
    int strobe_hi;
    int err_hi;
    int both_hi;
    int run_len;
    int max_run;
    int last_strobe_cyc;

    keypad_digit_loader #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .load         (load),
        .clear        (clear),
        .D            (D),
        .validn       (validn),
        .enablen      (enablen),
        .min_tens     (min_tens),
        .min_ones     (min_ones),
        .sec_tens     (sec_tens),
        .sec_ones     (sec_ones),
        .digit_count  (digit_count),
        .digit_strobe (digit_strobe),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (digit_strobe === 1'b1) begin
            strobe_hi       = strobe_hi + 1;
            last_strobe_cyc = cyc;
        end
        if (err === 1'b1) err_hi = err_hi + 1;
        if (digit_strobe === 1'b1 && err === 1'b1) both_hi = both_hi + 1;
        if (digit_strobe === 1'b1 || err === 1'b1) run_len = run_len + 1;
        else run_len = 0;
        if (run_len > max_run) max_run = run_len;
    end

    function automatic logic [15:0] digits();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d, input int lo, input int hi);
        D      = d;
        validn = 1'b0;
        tick(lo);
        validn = 1'b1;
        tick(hi);
    endtask

    task automatic test_reset();
        tick(2);
        total++;
        if (digits() !== 16'h0000 || digit_count !== 3'd0) begin
            bad++;
            $display("FAIL reset_digits: got %h/%0d want 0000/0", digits(), digit_count);
        end
        total++;
        if (enablen !== 1'b1 || digit_strobe !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags: got en=%b st=%b err=%b want 1 0 0", enablen, digit_strobe, err);
        end
        reset = 1'b0;
        tick(1);
        total++;
        if (enablen !== 1'b0) begin
            bad++;
            $display("FAIL enablen_after_reset: got %b want 0", enablen);
        end
    endtask

    task automatic test_four_digits();
        int s0;
        s0 = strobe_hi;
        press(4'd1, 10, 10);
        press(4'd2, 10, 10);
        press(4'd3, 10, 10);
        press(4'd0, 10, 10);
        total++;
        if (digits() !== 16'h1230) begin
            bad++;
            $display("FAIL four_digits: got %h want 1230", digits());
        end
        total++;
        if (digit_count !== 3'd4) begin
            bad++;
            $display("FAIL four_count: got %0d want 4", digit_count);
        end
        total++;
        if (strobe_hi - s0 != 4) begin
            bad++;
            $display("FAIL four_strobes: got %0d want 4", strobe_hi - s0);
        end
    endtask

    task automatic test_overflow();
        int s0;
        s0 = strobe_hi;
        press(4'd5, 10, 10);
        total++;
        if (digits() !== 16'h2305 || digit_count !== 3'd4) begin
            bad++;
            $display("FAIL overflow: got %h/%0d want 2305/4", digits(), digit_count);
        end
        total++;
        if (strobe_hi - s0 != 1) begin
            bad++;
            $display("FAIL overflow_strobe: got %0d want 1", strobe_hi - s0);
        end
    endtask

    task automatic test_glitch();
        int s0;
        s0 = strobe_hi;
        press(4'd7, 2, 10);
        total++;
        if (strobe_hi - s0 != 0 || digits() !== 16'h2305) begin
            bad++;
            $display("FAIL glitch: got strobes=%0d digits=%h want 0/2305", strobe_hi - s0, digits());
        end
    endtask

    task automatic test_bad_code();
        int s0;
        int e0;
        s0 = strobe_hi;
        e0 = err_hi;
        press(4'hF, 10, 10);
        total++;
        if (err_hi - e0 != 1) begin
            bad++;
            $display("FAIL bad_code_err: got %0d want 1", err_hi - e0);
        end
        total++;
        if (strobe_hi - s0 != 0 || digits() !== 16'h2305 || digit_count !== 3'd4) begin
            bad++;
            $display("FAIL bad_code_regs: got st=%0d %h/%0d want 0 2305/4", strobe_hi - s0, digits(), digit_count);
        end
    endtask

    task automatic test_held_key();
        int s0;
        int c0;
        s0     = strobe_hi;
        D      = 4'd9;
        c0     = cyc;
        validn = 1'b0;
        tick(50);
        validn = 1'b1;
        tick(2);
        validn = 1'b0;
        tick(1);
        validn = 1'b1;
        tick(10);
        total++;
        if (strobe_hi - s0 != 1 || digits() !== 16'h3059) begin
            bad++;
            $display("FAIL held_key: got st=%0d digits=%h want 1/3059", strobe_hi - s0, digits());
        end
        total++;
        if (last_strobe_cyc - (c0 + 1) != 4) begin
            bad++;
            $display("FAIL held_latency: got %0d want 4", last_strobe_cyc - (c0 + 1));
        end
    endtask

    task automatic test_clear_on_capture();
        int s0;
        int e0;
        s0     = strobe_hi;
        e0     = err_hi;
        D      = 4'd6;
        validn = 1'b0;
        tick(4);
        clear  = 1'b1;
        validn = 1'b1;
        tick(1);
        clear  = 1'b0;
        tick(8);
        total++;
        if (digits() !== 16'h0000 || digit_count !== 3'd0) begin
            bad++;
            $display("FAIL clear_capture: got %h/%0d want 0000/0", digits(), digit_count);
        end
        total++;
        if (strobe_hi - s0 != 0 || err_hi - e0 != 0) begin
            bad++;
            $display("FAIL clear_pulses: got st=%0d err=%0d want 0 0", strobe_hi - s0, err_hi - e0);
        end
    endtask

    task automatic test_reset_mid_press();
        press(4'd8, 10, 10);
        total++;
        if (digits() !== 16'h0008 || digit_count !== 3'd1) begin
            bad++;
            $display("FAIL pre_reset_digit: got %h/%0d want 0008/1", digits(), digit_count);
        end
        D      = 4'd3;
        validn = 1'b0;
        tick(2);
        reset  = 1'b1;
        tick(1);
        total++;
        if (digits() !== 16'h0000 || digit_count !== 3'd0 || enablen !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_press: got %h/%0d en=%b want 0000/0 en=1", digits(), digit_count, enablen);
        end
        validn = 1'b1;
        reset  = 1'b0;
        tick(10);
        total++;
        if (digits() !== 16'h0000 || enablen !== 1'b0) begin
            bad++;
            $display("FAIL post_reset: got %h en=%b want 0000 en=0", digits(), enablen);
        end
    endtask

    task automatic test_load_off();
        int s0;
        s0   = strobe_hi;
        load = 1'b0;
        @(negedge clk);
        total++;
        if (enablen !== 1'b0) begin
            bad++;
            $display("FAIL enablen_lag: got %b want 0", enablen);
        end
        tick(1);
        total++;
        if (enablen !== 1'b1) begin
            bad++;
            $display("FAIL enablen_rise: got %b want 1", enablen);
        end
        press(4'd2, 10, 10);
        total++;
        if (strobe_hi - s0 != 0 || digits() !== 16'h0000) begin
            bad++;
            $display("FAIL load_off_press: got st=%0d %h want 0 0000", strobe_hi - s0, digits());
        end
        load = 1'b1;
        tick(2);
        press(4'd4, 10, 10);
        total++;
        if (digits() !== 16'h0004 || digit_count !== 3'd1 || enablen !== 1'b0) begin
            bad++;
            $display("FAIL load_on_again: got %h/%0d en=%b want 0004/1 en=0", digits(), digit_count, enablen);
        end
    endtask

    task automatic test_pulse_rules();
        total++;
        if (both_hi != 0) begin
            bad++;
            $display("FAIL pulse_overlap: got %0d want 0", both_hi);
        end
        total++;
        if (max_run > 1) begin
            bad++;
            $display("FAIL pulse_width: got %0d want 1", max_run);
        end
    endtask

    initial begin
        total           = 0;
        bad             = 0;
        cyc             = 0;
        strobe_hi       = 0;
        err_hi          = 0;
        both_hi         = 0;
        run_len         = 0;
        max_run         = 0;
        last_strobe_cyc = 0;
        reset           = 1'b1;
        load            = 1'b1;
        clear           = 1'b0;
        D               = 4'd0;
        validn          = 1'b1;
        test_reset();
        test_four_digits();
        test_overflow();
        test_glitch();
        test_bad_code();
        test_held_key();
        test_clear_on_capture();
        test_reset_mid_press();
        test_load_off();
        test_pulse_rules();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keypad_digit_loader.md
Name: keypad_digit_loader

Overview:
- Receiving end of the keypad priority encoder interface.
- Consumes the encoder's BCD code and active-low valid strobe.
- Debounces key press and release, and rejects codes above 9.
- Shifts accepted digits into a 4-digit MM:SS entry register that feeds the cook timer. Also drives the encoder's active-low enable.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable clock samples required to accept a press and, separately, a release (legal range 1..255).
CNT_W, 8, width of the debounce counter; must hold DEBOUNCE_CYCLES.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
load  input  1  entry mode; high = key entry accepted.
clear  input  1  synchronous clear of entered digits.
D  input  4  BCD key code from the encoder.
validn  input  1  active-low key valid from the encoder.
enablen  output  1  active-low enable to the encoder; registered, equals ~load delayed one cycle.
min_tens  output  4  entered digit 3 (oldest).
min_ones  output  4  entered digit 2.
sec_tens  output  4  entered digit 1.
sec_ones  output  4  entered digit 0 (newest).
digit_count  output  3  digits entered, 0..4, saturates at 4.
digit_strobe  output  1  one-cycle pulse when a digit is accepted.
err  output  1  one-cycle pulse when a debounced press carries a code above 9.

Behaviour:
- Reset values: all digits 0, digit_count 0, digit_strobe 0, err 0, enablen 1, FSM in IDLE. Reset overrides everything.
- FSM states: IDLE, PRESS, CAPTURE, RELEASE.
- IDLE: when load=1 and validn=0, latch D into d_hold, set cnt=1, and go to PRESS.
- PRESS:
  - If validn=1 or D != d_hold, go to IDLE; this is a glitch and has no effect.
  - Otherwise increment cnt. When cnt reaches DEBOUNCE_CYCLES, go to CAPTURE.
- CAPTURE (exactly one cycle):
  - If d_hold <= 9: shift min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=d_hold. Increment digit_count, saturating at 4. Pulse digit_strobe.
  - If d_hold > 9: registers are unchanged and err pulses.
  - Then go to RELEASE with cnt=0.
- RELEASE:
  - Count consecutive validn=1 samples; any validn=0 resets cnt to 0.
  - When cnt reaches DEBOUNCE_CYCLES, go to IDLE.
  - A held key therefore yields exactly one digit.
- Latency: with DEBOUNCE_CYCLES=N, a clean press first sampled at edge k produces updated digits and digit_strobe high in the cycle after edge k+N.
- Overflow: a fifth and later digit keeps shifting; the oldest min_tens is discarded and digit_count stays 4.
- load falls in any state: FSM goes to IDLE next edge and digits are retained. enablen rises one cycle after load falls.
- clear=1: zero all digits and digit_count, FSM to IDLE, no strobe.
  - If clear coincides with CAPTURE, clear wins: no shift and no strobe, but err may still not pulse.
- digit_strobe and err are never high together and never high for more than one cycle.
- Register widths: digits fit in 4 bits by construction because values above 9 are rejected. No arithmetic carries between digits.

Test Plan:
- Reset, load=1, N=4. Press D=1, 2, 3, 0, each with validn low for 10 cycles and high for 10 cycles -> min_tens=1, min_ones=2, sec_tens=3, sec_ones=0, digit_count=4, exactly four digit_strobe pulses.
- Continue from above: press D=5 -> digits 2,3,0,5; digit_count stays 4.
- validn low for 2 cycles with D=7, then high -> no strobe, digits unchanged, FSM back in IDLE.
- validn low for 10 cycles with D=4'b1111 -> one err pulse, no strobe, digits unchanged.
- Key D=9 held low for 50 cycles -> exactly one strobe, sec_ones=9, and the strobe comes 4 cycles after the first low sample. Within the release window, bounce validn high/low/high -> still a single digit.
- clear asserted on the CAPTURE cycle -> all digits 0, digit_count 0, no strobe.
- reset asserted mid-PRESS -> outputs at reset values next cycle, enablen=1.
- load=0 -> presses ignored, enablen=1 one cycle after load falls.
